// File: rtl/dbram_pingpong_if.sv
// Producer/consumer bus for the dbram_pingpong double-buffered RAM.
// master = producer/consumer side, slave = buffer side.
interface dbram_pingpong_if #(
    parameter int unsigned AWIDTH = 11,
    parameter int unsigned DWIDTH = 40
);
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic              rd_en;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release;
    logic              rd_ready;
    logic              wr_bank;
    logic              rd_bank;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
        input  wr_ready, rd_data, rd_valid, rd_ready, wr_bank, rd_bank,
               err_overflow, err_underflow
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
        output wr_ready, rd_data, rd_valid, rd_ready, wr_bank, rd_bank,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/dbram_pingpong.sv
// Two-bank ping-pong buffer: producer fills one bank while the consumer drains the other.
// Define DBRAM_PINGPONG_OUTREG_EN to add an output register (read latency 2 instead of 1).
module dbram_pingpong #(
    parameter int unsigned AWIDTH    = 11,
    parameter int unsigned NUM_WORDS = 2048,
    parameter int unsigned DWIDTH    = 40
) (
    input logic               clk,
    input logic               reset,
    dbram_pingpong_if.slave   bus
);
    typedef enum logic {StEmpty, StFull} bank_state_e;

    logic [DWIDTH-1:0] mem0 [NUM_WORDS];
    logic [DWIDTH-1:0] mem1 [NUM_WORDS];

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;
    logic        err_overflow_q, err_overflow_d;
    logic        err_underflow_q, err_underflow_d;
    logic [DWIDTH-1:0] rd_data_q;
    logic              rd_valid_q;

    logic wr_ready, rd_ready;
    logic wr_fire, commit_ok, rd_fire, release_ok;

    assign wr_ready   = (bank_q[wp_q] == StEmpty);
    assign rd_ready   = (bank_q[rp_q] == StFull);
    assign wr_fire    = bus.wr_en && wr_ready;
    assign commit_ok  = bus.wr_commit && wr_ready;
    assign rd_fire    = bus.rd_en && rd_ready;
    assign release_ok = bus.rd_release && rd_ready;

    // Legal commit and release can never hit the same bank: one is empty, the other full.
    always_comb begin
        bank_d          = bank_q;
        wp_d            = wp_q;
        rp_d            = rp_q;
        err_overflow_d  = err_overflow_q  | ((bus.wr_en | bus.wr_commit) & ~wr_ready);
        err_underflow_d = err_underflow_q | ((bus.rd_en | bus.rd_release) & ~rd_ready);
        if (commit_ok) begin
            bank_d[wp_q] = StFull;
            wp_d         = ~wp_q;
        end
        if (release_ok) begin
            bank_d[rp_q] = StEmpty;
            rp_d         = ~rp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]       <= StEmpty;
            bank_q[1]       <= StEmpty;
            wp_q            <= 1'b0;
            rp_q            <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            bank_q          <= bank_d;
            wp_q            <= wp_d;
            rp_q            <= rp_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            if (wp_q) mem1[bus.wr_addr] <= bus.wr_data;
            else      mem0[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_data_q <= rp_q ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
        end
    end

`ifdef DBRAM_PINGPONG_OUTREG_EN
    logic [DWIDTH-1:0] out_data_q;
    logic              out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) out_data_q <= rd_data_q;
        end
    end

    assign bus.rd_data  = out_data_q;
    assign bus.rd_valid = out_valid_q;
`else
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.wr_ready      = wr_ready;
    assign bus.rd_ready      = rd_ready;
    assign bus.wr_bank       = wp_q;
    assign bus.rd_bank       = rp_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_dbram_pingpong.sv
// Directed self-checking bench for dbram_pingpong (both read-latency builds).
module tb_dbram_pingpong;
    localparam int unsigned AW = 4;
    localparam int unsigned NW = 16;
    localparam int unsigned DW = 40;
`ifdef DBRAM_PINGPONG_OUTREG_EN
    localparam int RdLat = 2;
`else
    localparam int RdLat = 1;
`endif

    logic clk;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    dbram_pingpong_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    dbram_pingpong #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic rel,
                           input logic [DW-1:0] exp, input string tag);
        bus.rd_en      = 1'b1;
        bus.rd_addr    = addr;
        bus.rd_release = rel;
        tick();
        bus.rd_en      = 1'b0;
        bus.rd_release = 1'b0;
        for (int k = 1; k < RdLat; k++) begin
            check({tag, "_early"}, 64'(bus.rd_valid), 64'd0);
            tick();
        end
        check({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic fill4(input logic [DW-1:0] base, input logic commit);
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(i);
            bus.wr_data = base + DW'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        if (commit) begin
            bus.wr_commit = 1'b1;
            tick();
            bus.wr_commit = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_commit = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_release = 1'b0;
        do_reset();
        tick();

        // Idle after reset
        check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
        check("rst_wr_bank", 64'(bus.wr_bank), 64'd0);
        check("rst_rd_bank", 64'(bus.rd_bank), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        check("rst_ovf", 64'(bus.err_overflow), 64'd0);
        check("rst_unf", 64'(bus.err_underflow), 64'd0);

        // Read with nothing committed
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("unf_flag", 64'(bus.err_underflow), 64'd1);
        for (int k = 0; k < RdLat; k++) begin
            check("unf_no_valid", 64'(bus.rd_valid), 64'd0);
            tick();
        end
        check("unf_sticky", 64'(bus.err_underflow), 64'd1);
        do_reset();
        tick();
        check("unf_cleared", 64'(bus.err_underflow), 64'd0);

        // Fill bank 0, commit, read address 2
        fill4(40'h11, 1'b1);
        check("c0_wr_bank", 64'(bus.wr_bank), 64'd1);
        check("c0_rd_ready", 64'(bus.rd_ready), 64'd1);
        check("c0_wr_ready", 64'(bus.wr_ready), 64'd1);
        do_read(4'd2, 1'b0, 40'h13, "rd_a2");
        tick();
        check("hold_valid", 64'(bus.rd_valid), 64'd0);
        check("hold_data", 64'(bus.rd_data), 64'h13);

        // Fill bank 1 too: both full, extra write must be rejected
        fill4(40'h21, 1'b1);
        check("both_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("both_wr_bank", 64'(bus.wr_bank), 64'd0);
        check("both_ovf0", 64'(bus.err_overflow), 64'd0);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 40'hEE;
        tick();
        bus.wr_en = 1'b0;
        check("ovf_flag", 64'(bus.err_overflow), 64'd1);
        do_read(4'd0, 1'b0, 40'h11, "b0_intact");

        // Read together with release returns old-bank data
        do_read(4'd3, 1'b1, 40'h14, "rel_rd");
        check("rel_rd_bank", 64'(bus.rd_bank), 64'd1);
        check("rel_wr_bank", 64'(bus.wr_bank), 64'd0);
        check("rel_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("rel_rd_ready", 64'(bus.rd_ready), 64'd1);

        // Refill bank 0, check bank 1, then commit bank 0 while releasing bank 1
        fill4(40'h31, 1'b0);
        do_read(4'd0, 1'b0, 40'h21, "b1_intact");
        bus.wr_commit = 1'b1; bus.rd_release = 1'b1;
        tick();
        bus.wr_commit = 1'b0; bus.rd_release = 1'b0;
        check("swap_rd_bank", 64'(bus.rd_bank), 64'd0);
        check("swap_wr_bank", 64'(bus.wr_bank), 64'd1);
        check("swap_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("swap_rd_ready", 64'(bus.rd_ready), 64'd1);
        check("swap_ovf_sticky", 64'(bus.err_overflow), 64'd1);
        do_read(4'd1, 1'b0, 40'h32, "b0_new");

        // Reset with a read in flight
        bus.rd_en = 1'b1; bus.rd_addr = 4'd1;
        tick();
        bus.rd_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("mid_rd_data", 64'(bus.rd_data), 64'd0);
        check("mid_ovf", 64'(bus.err_overflow), 64'd0);
        check("mid_unf", 64'(bus.err_underflow), 64'd0);
        check("mid_wr_bank", 64'(bus.wr_bank), 64'd0);
        check("mid_rd_bank", 64'(bus.rd_bank), 64'd0);
        tick();
        check("mid_rd_valid2", 64'(bus.rd_valid), 64'd0);
        check("mid_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("mid_rd_ready", 64'(bus.rd_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
